// File: rtl/passcode_pkg.sv
// Shared definitions for the passcode controller: FSM encoding, BCD digit
// width and default code length.
package passcode_pkg;

  // Width of one BCD digit in the entry buffer and stored code.
  localparam int unsigned BcdW = 4;

  // Default number of digits in a passcode.
  localparam int unsigned DigitsDefault = 8;

  // Largest legal BCD value on key_code.
  localparam logic [BcdW-1:0] BcdMax = 4'd9;

  // Controller states.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StCheck    = 3'd1,
    StUnlocked = 3'd2,
    StSet      = 3'd3,
    StLockout  = 3'd4
  } state_e;

  // True when a keypad code is a legal decimal digit.
  function automatic logic is_bcd(input logic [BcdW-1:0] key);
    return key <= BcdMax;
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Down-counter that holds the controller in lockout for a fixed number of
// cycles. load_i arms it; en_i is high for every cycle spent in lockout and
// done_o marks the final one.
module lockout_timer #(
  parameter int unsigned Cycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned Width = (Cycles < 1) ? 1 : $clog2(Cycles + 1);
  localparam logic [Width-1:0] LoadVal = Width'(Cycles);
  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;

  // Next count: reload on arm, otherwise count down while enabled.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LoadVal;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - One;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A count of zero while enabled also ends lockout, so the FSM can never stick.
  assign done_o = en_i && (count_q <= One);

endmodule

// File: rtl/passcode_ctrl.sv
// Keypad passcode controller: collects BCD digits, checks them against a
// stored code, counts consecutive failures into a timed lockout and lets an
// unlocked user replace the stored code.
module passcode_ctrl
  import passcode_pkg::*;
#(
  parameter int unsigned DIGITS      = DigitsDefault,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter logic [DIGITS*BcdW-1:0] DEFAULT_CODE = 32'h1234_5678
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       enter,
  input  logic       clear,
  input  logic       set_req,
  input  logic       lock,
  output logic       unlocked,
  output logic       locked_out,
  output logic       fail_pulse,
  output logic       set_done,
  output logic       set_err,
  output logic [3:0] digit_cnt,
  output logic [1:0] fail_cnt
);

  localparam int unsigned EntryW = DIGITS * BcdW;
  localparam logic [3:0] DigitsFull = 4'(DIGITS);
  localparam logic [1:0] FailLimit = 2'(MAX_FAIL);

  state_e state_q, state_d;

  logic [EntryW-1:0] entry_q, entry_d;
  logic [EntryW-1:0] code_q, code_d;
  logic [3:0]        digit_cnt_q, digit_cnt_d;
  logic [1:0]        fail_cnt_q, fail_cnt_d;
  logic              fail_pulse_q, fail_pulse_d;
  logic              set_done_q, set_done_d;
  logic              set_err_q, set_err_d;

  logic              buf_full;
  logic              key_ok;
  logic              code_match;
  logic [1:0]        fail_inc;
  logic              fail_limit_hit;
  logic [EntryW-1:0] entry_shifted;
  logic              timer_load;
  logic              timer_en;
  logic              timer_done;

  // Shared decode of the entry buffer and failure counter.
  assign buf_full       = (digit_cnt_q == DigitsFull);
  assign key_ok         = key_valid && is_bcd(key_code) && !buf_full;
  assign code_match     = buf_full && (entry_q == code_q);
  assign fail_inc       = fail_cnt_q + 2'd1;
  assign fail_limit_hit = (fail_inc >= FailLimit);
  assign entry_shifted  = (entry_q << BcdW) | EntryW'(key_code);
  assign timer_en       = (state_q == StLockout);

  lockout_timer #(
    .Cycles(LOCK_CYCLES)
  ) u_lockout_timer (
    .clk_i (clk),
    .rst_i (rst),
    .load_i(timer_load),
    .en_i  (timer_en),
    .done_o(timer_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear outranks enter, which outranks digit entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!clear && enter) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (code_match) begin
          state_d = StUnlocked;
        end else if (fail_limit_hit) begin
          state_d = StLockout;
        end else begin
          state_d = StIdle;
        end
      end
      StUnlocked: begin
        if (lock) begin
          state_d = StIdle;
        end else if (set_req) begin
          state_d = StSet;
        end
      end
      StSet: begin
        if (!clear && enter) begin
          state_d = StUnlocked;
        end
      end
      StLockout: begin
        if (timer_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: entry buffer, stored code, failure count, pulses.
  always_comb begin
    entry_d      = entry_q;
    digit_cnt_d  = digit_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    code_d       = code_q;
    fail_pulse_d = 1'b0;
    set_done_d   = 1'b0;
    set_err_d    = 1'b0;
    timer_load   = 1'b0;
    case (state_q)
      StIdle: begin
        if (clear) begin
          entry_d     = '0;
          digit_cnt_d = '0;
        end else if (!enter && key_ok) begin
          // With enter pending the buffer is held unchanged for the check.
          entry_d     = entry_shifted;
          digit_cnt_d = digit_cnt_q + 4'd1;
        end
      end
      StCheck: begin
        entry_d     = '0;
        digit_cnt_d = '0;
        if (code_match) begin
          fail_cnt_d = '0;
        end else begin
          fail_cnt_d   = fail_inc;
          fail_pulse_d = 1'b1;
          timer_load   = fail_limit_hit;
        end
      end
      StUnlocked: begin
        // Digits are ignored here; keep the buffer empty for the next SET.
        entry_d     = '0;
        digit_cnt_d = '0;
      end
      StSet: begin
        if (clear) begin
          entry_d     = '0;
          digit_cnt_d = '0;
        end else if (enter) begin
          if (buf_full) begin
            code_d     = entry_q;
            set_done_d = 1'b1;
          end else begin
            set_err_d = 1'b1;
          end
          entry_d     = '0;
          digit_cnt_d = '0;
        end else if (key_ok) begin
          entry_d     = entry_shifted;
          digit_cnt_d = digit_cnt_q + 4'd1;
        end
      end
      StLockout: begin
        if (timer_done) begin
          fail_cnt_d = '0;
        end
      end
      default: begin
        entry_d     = '0;
        digit_cnt_d = '0;
      end
    endcase
  end

  // Datapath registers; reset restores the factory code.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q      <= '0;
      digit_cnt_q  <= '0;
      fail_cnt_q   <= '0;
      code_q       <= DEFAULT_CODE;
      fail_pulse_q <= 1'b0;
      set_done_q   <= 1'b0;
      set_err_q    <= 1'b0;
    end else begin
      entry_q      <= entry_d;
      digit_cnt_q  <= digit_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      code_q       <= code_d;
      fail_pulse_q <= fail_pulse_d;
      set_done_q   <= set_done_d;
      set_err_q    <= set_err_d;
    end
  end

  // Outputs: status decoded from state, pulses and counts straight from flops.
  always_comb begin
    unlocked   = (state_q == StUnlocked) || (state_q == StSet);
    locked_out = (state_q == StLockout);
    fail_pulse = fail_pulse_q;
    set_done   = set_done_q;
    set_err    = set_err_q;
    digit_cnt  = digit_cnt_q;
    fail_cnt   = fail_cnt_q;
  end

endmodule

// File: tb/tb_passcode_ctrl.sv
// Directed and random checks of passcode_ctrl against a digit-queue model.
module tb_passcode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       enter;
  logic       clear;
  logic       set_req;
  logic       lock;
  logic       unlocked;
  logic       locked_out;
  logic       fail_pulse;
  logic       set_done;
  logic       set_err;
  logic [3:0] digit_cnt;
  logic [1:0] fail_cnt;

  passcode_ctrl #(
    .DIGITS      (8),
    .MAX_FAIL    (3),
    .LOCK_CYCLES (16),
    .DEFAULT_CODE(32'h1234_5678)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .enter     (enter),
    .clear     (clear),
    .set_req   (set_req),
    .lock      (lock),
    .unlocked  (unlocked),
    .locked_out(locked_out),
    .fail_pulse(fail_pulse),
    .set_done  (set_done),
    .set_err   (set_err),
    .digit_cnt (digit_cnt),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: entry is a queue of decimal digits, code an array of digits.
  localparam int MIdle = 0, MCheck = 1, MUnl = 2, MSet = 3, MLock = 4;
  int m_mode;
  int m_buf[$];
  int m_code[8];
  int m_fail;
  int m_left;
  bit m_fp, m_sd, m_se;

  function automatic void m_reset();
    m_mode = MIdle;
    m_buf.delete();
    for (int i = 0; i < 8; i++) m_code[i] = i + 1;
    m_fail = 0;
    m_left = 0;
    m_fp = 0;
    m_sd = 0;
    m_se = 0;
  endfunction

  function automatic bit m_match();
    if (m_buf.size() != 8) return 0;
    for (int i = 0; i < 8; i++) if (m_buf[i] != m_code[i]) return 0;
    return 1;
  endfunction

  function automatic void m_step(bit r, bit kv, logic [3:0] kc, bit en, bit cl, bit sr, bit lk);
    bit ok;
    m_fp = 0;
    m_sd = 0;
    m_se = 0;
    if (r) begin
      m_reset();
      return;
    end
    case (m_mode)
      MIdle: begin
        if (cl) m_buf.delete();
        else if (en) m_mode = MCheck;
        else if (kv && kc <= 9 && m_buf.size() < 8) m_buf.push_back(int'(kc));
      end
      MCheck: begin
        ok = m_match();
        m_buf.delete();
        if (ok) begin
          m_mode = MUnl;
          m_fail = 0;
        end else begin
          m_fail++;
          m_fp = 1;
          if (m_fail >= 3) begin
            m_mode = MLock;
            m_left = 16;
          end else begin
            m_mode = MIdle;
          end
        end
      end
      MUnl: begin
        if (lk) m_mode = MIdle;
        else if (sr) m_mode = MSet;
      end
      MSet: begin
        if (cl) m_buf.delete();
        else if (en) begin
          if (m_buf.size() == 8) begin
            for (int i = 0; i < 8; i++) m_code[i] = m_buf[i];
            m_sd = 1;
          end else begin
            m_se = 1;
          end
          m_buf.delete();
          m_mode = MUnl;
        end else if (kv && kc <= 9 && m_buf.size() < 8) m_buf.push_back(int'(kc));
      end
      MLock: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = MIdle;
          m_fail = 0;
        end
      end
      default: m_mode = MIdle;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".unlocked"}, unlocked, (m_mode == MUnl || m_mode == MSet) ? 1 : 0);
    check({tag, ".locked_out"}, locked_out, (m_mode == MLock) ? 1 : 0);
    check({tag, ".fail_pulse"}, fail_pulse, m_fp);
    check({tag, ".set_done"}, set_done, m_sd);
    check({tag, ".set_err"}, set_err, m_se);
    check({tag, ".digit_cnt"}, digit_cnt, m_buf.size());
    check({tag, ".fail_cnt"}, fail_cnt, m_fail);
  endtask

  // One clock: drive inputs, let the edge pass, update model, compare.
  task automatic step(input bit r, input bit kv, input logic [3:0] kc, input bit en,
                      input bit cl, input bit sr, input bit lk, input string tag);
    rst = r; key_valid = kv; key_code = kc; enter = en; clear = cl; set_req = sr; lock = lk;
    @(posedge clk);
    m_step(r, kv, kc, en, cl, sr, lk);
    #1;
    check_model(tag);
    rst = 0; key_valid = 0; key_code = 0; enter = 0; clear = 0; set_req = 0; lock = 0;
  endtask

  task automatic idle(input string tag);
    step(0, 0, 4'd0, 0, 0, 0, 0, tag);
  endtask

  task automatic do_reset();
    step(1, 0, 4'd0, 0, 0, 0, 0, "reset");
  endtask

  task automatic key(input int d, input string tag);
    step(0, 1, 4'(d), 0, 0, 0, 0, tag);
  endtask

  task automatic press_enter(input string tag);
    step(0, 0, 4'd0, 1, 0, 0, 0, tag);
  endtask

  task automatic type_code(input int first, input int dir, input int n, input string tag);
    for (int i = 0; i < n; i++) key(first + dir * i, tag);
  endtask

  initial begin
    int n;
    m_reset();
    rst = 1; key_valid = 0; key_code = 0; enter = 0; clear = 0; set_req = 0; lock = 0;

    // Reset state.
    do_reset();
    do_reset();
    check("rst.unlocked", unlocked, 0);
    check("rst.locked_out", locked_out, 0);
    check("rst.digit_cnt", digit_cnt, 0);
    check("rst.fail_cnt", fail_cnt, 0);

    // Correct default code unlocks two cycles after enter.
    type_code(1, 1, 8, "unlock_keys");
    check("unlock.digits", digit_cnt, 8);
    press_enter("unlock_enter");
    check("unlock.check_cycle", unlocked, 0);
    idle("unlock_wait");
    check("unlock.unlocked", unlocked, 1);
    check("unlock.fail_cnt", fail_cnt, 0);
    step(0, 0, 4'd0, 0, 0, 1, 1, "relock");
    check("relock.unlocked", unlocked, 0);

    // Short code fails once.
    type_code(1, 1, 7, "short_keys");
    press_enter("short_enter");
    idle("short_wait");
    check("short.fail_pulse", fail_pulse, 1);
    check("short.fail_cnt", fail_cnt, 1);
    check("short.digit_cnt", digit_cnt, 0);
    check("short.unlocked", unlocked, 0);
    idle("short_after");
    check("short.pulse_once", fail_pulse, 0);

    // Three wrong codes lock out for exactly 16 cycles.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) key(9, "wrong_keys");
      press_enter("wrong_enter");
      idle("wrong_wait");
    end
    check("lockout.entered", locked_out, 1);
    n = 0;
    while (locked_out === 1'b1 && n < 40) begin
      n++;
      step(0, 1, 4'($urandom_range(0, 9)), ($urandom_range(0, 3) == 0), 0,
           ($urandom_range(0, 3) == 0), 0, "lockout_keys");
    end
    check("lockout.cycles", n, 16);
    check("lockout.fail_cnt", fail_cnt, 0);
    check("lockout.digit_cnt", digit_cnt, 0);

    // Code change, old code rejected, new code accepted.
    type_code(1, 1, 8, "set_unlock");
    press_enter("set_unlock");
    idle("set_unlock");
    step(0, 0, 4'd0, 0, 0, 1, 0, "set_req");
    check("set.unlocked_in_set", unlocked, 1);
    type_code(8, -1, 8, "set_keys");
    press_enter("set_enter");
    check("set.set_done", set_done, 1);
    check("set.unlocked", unlocked, 1);
    step(0, 0, 4'd0, 0, 0, 0, 1, "set_lock");
    type_code(1, 1, 8, "old_code");
    press_enter("old_code");
    idle("old_code");
    check("old_code.unlocked", unlocked, 0);
    check("old_code.fail_pulse", fail_pulse, 1);
    type_code(8, -1, 8, "new_code");
    press_enter("new_code");
    idle("new_code");
    check("new_code.unlocked", unlocked, 1);
    step(0, 0, 4'd0, 0, 0, 0, 1, "new_lock");

    // SET aborted with a short entry.
    type_code(8, -1, 8, "err_unlock");
    press_enter("err_unlock");
    idle("err_unlock");
    step(0, 0, 4'd0, 0, 0, 1, 0, "err_set");
    type_code(1, 1, 3, "err_keys");
    press_enter("err_enter");
    check("set_err.pulse", set_err, 1);
    check("set_err.unlocked", unlocked, 1);
    step(0, 0, 4'd0, 0, 0, 0, 1, "err_lock");

    // Enter beats a same-cycle key; non-BCD key ignored; clear beats everything.
    do_reset();
    type_code(1, 1, 8, "prio_keys");
    step(0, 1, 4'd9, 1, 0, 0, 0, "prio_enter");
    idle("prio_wait");
    check("prio.unlocked", unlocked, 1);
    step(0, 0, 4'd0, 0, 0, 0, 1, "prio_lock");
    type_code(1, 1, 4, "bcd_keys");
    step(0, 1, 4'hA, 0, 0, 0, 0, "bcd_a");
    check("bcd.digit_cnt", digit_cnt, 4);
    step(0, 1, 4'd5, 1, 1, 0, 0, "clear_prio");
    check("clear.digit_cnt", digit_cnt, 0);
    check("clear.unlocked", unlocked, 0);

    // Reset mid-SET restores the default code.
    type_code(1, 1, 8, "rs_unlock");
    press_enter("rs_unlock");
    idle("rs_unlock");
    step(0, 0, 4'd0, 0, 0, 1, 0, "rs_set");
    for (int i = 0; i < 8; i++) key(5, "rs_keys");
    press_enter("rs_commit");
    check("rs.set_done", set_done, 1);
    step(0, 0, 4'd0, 0, 0, 1, 0, "rs_set2");
    type_code(8, -1, 4, "rs_partial");
    step(1, 1, 4'd3, 1, 0, 1, 0, "rs_reset");
    check("rs.unlocked", unlocked, 0);
    check("rs.digit_cnt", digit_cnt, 0);
    check("rs.set_done", set_done, 0);
    type_code(1, 1, 8, "rs_default");
    press_enter("rs_default");
    idle("rs_default");
    check("rs.default_code", unlocked, 1);

    // Random traffic against the model.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 99) < 12) begin
        for (int i = 0; i < 8; i++) key(m_code[i], "rnd_code");
        press_enter("rnd_code");
      end else begin
        step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), 4'($urandom_range(0, 11)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/passcode_ctrl.md
PASSCODE_CTRL -- requirements
Module: passcode_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8: code length in BCD digits (4 bits each).
REQ-002 SHALL have parameter MAX_FAIL, default 3: consecutive failed checks that trigger lockout.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16: lockout duration in clk cycles.
REQ-004 SHALL have parameter DEFAULT_CODE, default 32'h1234_5678: code loaded at reset.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 key_valid  in  1  one-cycle strobe, key_code valid.
REQ-008 key_code  in  4  BCD digit 0-9.
REQ-009 enter  in  1  one-cycle strobe, submit current entry.
REQ-010 clear  in  1  one-cycle strobe, discard current entry.
REQ-011 set_req  in  1  request code change (honoured only in UNLOCKED).
REQ-012 lock  in  1  relock request (honoured only in UNLOCKED).
REQ-013 unlocked  out  1  high while in UNLOCKED or SET.
REQ-014 locked_out  out  1  high while in LOCKOUT.
REQ-015 fail_pulse  out  1  one-cycle pulse per failed check.
REQ-016 set_done  out  1  one-cycle pulse when new code committed.
REQ-017 set_err  out  1  one-cycle pulse when SET aborted.
REQ-018 digit_cnt  out  4  digits held in entry buffer, 0..DIGITS.
REQ-019 fail_cnt  out  2  consecutive failures, 0..MAX_FAIL-1 outside LOCKOUT.

Function
REQ-020 FSM states SHALL be IDLE, CHECK, UNLOCKED, SET, LOCKOUT; IDLE accepts digits.
REQ-021 Accepted digit (IDLE or SET, key_valid, key_code<=9, digit_cnt<DIGITS) SHALL shift entry left 4 bits with key_code in LSBs, digit_cnt+1.
REQ-022 key_code>9, or digit_cnt==DIGITS, SHALL be ignored without state change.
REQ-023 Priority per cycle SHALL be clear > enter > key_valid; lower-priority strobes that cycle are dropped.
REQ-024 clear SHALL zero entry and digit_cnt only; fail_cnt and state unchanged.
REQ-025 enter in IDLE SHALL move to CHECK next cycle; in CHECK, match = (digit_cnt==DIGITS && entry==code).
REQ-026 Match: next state UNLOCKED, fail_cnt<=0; result visible two cycles after enter.
REQ-027 Mismatch: fail_pulse high one cycle, fail_cnt+1; if it reaches MAX_FAIL go LOCKOUT, else IDLE.
REQ-028 Leaving CHECK SHALL always zero entry and digit_cnt.
REQ-029 LOCKOUT SHALL ignore all inputs for exactly LOCK_CYCLES cycles, then enter IDLE with fail_cnt<=0.
REQ-030 UNLOCKED: lock -> IDLE; set_req -> SET (lock wins if both); digits/enter ignored.
REQ-031 SET with enter and digit_cnt==DIGITS SHALL write code<=entry, pulse set_done, return UNLOCKED.
REQ-032 SET with enter and digit_cnt<DIGITS SHALL pulse set_err, keep code, return UNLOCKED.
REQ-033 Leaving SET SHALL zero entry and digit_cnt; clear in SET only clears the buffer.

Reset
REQ-034 rst SHALL force IDLE, entry=0, digit_cnt=0, fail_cnt=0, lockout counter=0, code=DEFAULT_CODE.
REQ-035 After rst all outputs SHALL be 0 (unlocked, locked_out, pulses, counts).
REQ-036 rst SHALL override every other input in any state, including mid-LOCKOUT and mid-SET.

Structure
REQ-037 State encoding, DIGITS default, and BCD width constant SHALL live in shared package passcode_pkg.
REQ-038 Lockout timer SHALL be sub-module lockout_timer (load, count-down, done pulse), width clog2(LOCK_CYCLES+1).
REQ-039 Entry/code compare SHALL be combinational equality of DIGITS*4-bit vectors.

Verification
REQ-040 Reset, keys 1,2,3,4,5,6,7,8, enter -> unlocked=1 two cycles after enter, fail_cnt=0.
REQ-041 Keys 1..7 (7 digits), enter -> fail_pulse=1 once, fail_cnt=1, state IDLE, digit_cnt=0.
REQ-042 Three wrong 8-digit codes -> locked_out=1 for exactly 16 cycles; keys during lockout ignored; then IDLE, fail_cnt=0.
REQ-043 Unlock, set_req, keys 8,7,6,5,4,3,2,1, enter -> set_done; lock; old code fails, 8765_4321 unlocks.
REQ-044 Same-cycle key_valid+enter with 8 digits held -> key dropped, check uses held 8 digits; key_code=4'hA ignored.
REQ-045 rst asserted mid-SET after 4 digits -> IDLE, code=1234_5678, all outputs 0.
